// File: rtl/hazard_ctrl_pipe_if.sv
// Decoder-side and pipeline-control signal bundle for hazard_ctrl_pipe.
// The slave modport is the hazard unit; master is whatever drives the decoder fields.
interface hazard_ctrl_pipe_if;
  logic [8:0] ctrl_i;
  logic       branch_i;
  logic       jump_i;
  logic       eq_i;
  logic [4:0] rs_i;
  logic [4:0] rt_i;
  logic [4:0] rd_i;

  logic       ex_alusrc_o;
  logic [1:0] ex_aluop_o;
  logic       ex_regdst_o;
  logic       mem_memread_o;
  logic       mem_memwrite_o;
  logic       wb_regwrite_o;
  logic       wb_memtoreg_o;
  logic [4:0] wb_rd_o;
  logic [1:0] fwd_a_o;
  logic [1:0] fwd_b_o;
  logic       pc_write_o;
  logic       ifid_write_o;
  logic       flush_o;

  modport master (
    output ctrl_i, branch_i, jump_i, eq_i, rs_i, rt_i, rd_i,
    input  ex_alusrc_o, ex_aluop_o, ex_regdst_o, mem_memread_o, mem_memwrite_o,
           wb_regwrite_o, wb_memtoreg_o, wb_rd_o, fwd_a_o, fwd_b_o,
           pc_write_o, ifid_write_o, flush_o
  );

  modport slave (
    input  ctrl_i, branch_i, jump_i, eq_i, rs_i, rt_i, rd_i,
    output ex_alusrc_o, ex_aluop_o, ex_regdst_o, mem_memread_o, mem_memwrite_o,
           wb_regwrite_o, wb_memtoreg_o, wb_rd_o, fwd_a_o, fwd_b_o,
           pc_write_o, ifid_write_o, flush_o
  );
endinterface

// File: rtl/hazard_ctrl_pipe.sv
// Control-path pipeline (ID/EX, EX/MEM, MEM/WB) with load-use stall,
// branch/jump flush and EX-stage operand forwarding selects.
module hazard_ctrl_pipe (
  input  logic              clk_i,
  input  logic              rst_i,
  hazard_ctrl_pipe_if.slave bus
);

  logic [8:0] ctrl_p0;
  logic [4:0] rs_p0;
  logic [4:0] rt_p0;
  logic [4:0] rd_p0;
  logic [3:0] ctrl_p1;
  logic [4:0] dest_p1;
  logic [1:0] ctrl_p2;
  logic [4:0] dest_p2;

  logic       stall;
  logic [4:0] dest_ex;
  logic       unused_branch;

  // Newer producer (EX/MEM) wins over older (MEM/WB); r0 never forwards.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       mem_wr,
    input logic [4:0] mem_dest,
    input logic       wb_wr,
    input logic [4:0] wb_dest
  );
    if (mem_wr && (mem_dest != 5'd0) && (mem_dest == src))
      return 2'b10;
    else if (wb_wr && (wb_dest != 5'd0) && (wb_dest == src))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  always_comb begin
    stall   = ctrl_p0[5] && (rt_p0 != 5'd0) &&
              ((rt_p0 == bus.rs_i) || (rt_p0 == bus.rt_i));
    dest_ex = ctrl_p0[3] ? rd_p0 : rt_p0;
  end

  // Branch is resolved in ID; its ID/EX copy is carried but never consumed.
  assign unused_branch = ctrl_p0[4];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ctrl_p0 <= '0;
      rs_p0   <= '0;
      rt_p0   <= '0;
      rd_p0   <= '0;
      ctrl_p1 <= '0;
      dest_p1 <= '0;
      ctrl_p2 <= '0;
      dest_p2 <= '0;
    end else begin
      // ID -> EX: a stall injects a bubble, register fields still advance
      ctrl_p0 <= stall ? 9'h000 : bus.ctrl_i;
      rs_p0   <= bus.rs_i;
      rt_p0   <= bus.rt_i;
      rd_p0   <= bus.rd_i;
      // EX -> MEM
      ctrl_p1 <= ctrl_p0[8:5];
      dest_p1 <= dest_ex;
      // MEM -> WB
      ctrl_p2 <= ctrl_p1[3:2];
      dest_p2 <= dest_p1;
    end
  end

  assign bus.ex_alusrc_o    = ctrl_p0[0];
  assign bus.ex_aluop_o     = ctrl_p0[2:1];
  assign bus.ex_regdst_o    = ctrl_p0[3];
  assign bus.mem_memread_o  = ctrl_p1[0];
  assign bus.mem_memwrite_o = ctrl_p1[1];
  assign bus.wb_regwrite_o  = ctrl_p2[0];
  assign bus.wb_memtoreg_o  = ctrl_p2[1];
  assign bus.wb_rd_o        = dest_p2;

  assign bus.fwd_a_o = fwd_sel(rs_p0, ctrl_p1[2], dest_p1, ctrl_p2[0], dest_p2);
  assign bus.fwd_b_o = fwd_sel(rt_p0, ctrl_p1[2], dest_p1, ctrl_p2[0], dest_p2);

  assign bus.pc_write_o   = ~stall;
  assign bus.ifid_write_o = ~stall;
  assign bus.flush_o      = (bus.jump_i | (bus.branch_i & bus.eq_i)) & ~stall;

endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Randomized and directed bench for hazard_ctrl_pipe against a history-based
// model: index 0/1/2 of the history are the last three instructions issued.
module tb_hazard_ctrl_pipe;
  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  hazard_ctrl_pipe_if bus ();
  hazard_ctrl_pipe dut (.clk_i(clk), .rst_i(rst_i), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [8:0] h_ctrl [3];
  logic [4:0] h_rs   [3];
  logic [4:0] h_rt   [3];
  logic [4:0] h_rd   [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic m_stall();
    return h_ctrl[0][5] && (h_rt[0] != 5'd0) &&
           ((h_rt[0] == bus.rs_i) || (h_rt[0] == bus.rt_i));
  endfunction

  function automatic logic [4:0] m_dest(input int k);
    return h_ctrl[k][3] ? h_rd[k] : h_rt[k];
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] src);
    if (h_ctrl[1][7] && m_dest(1) != 5'd0 && m_dest(1) == src) return 2'b10;
    if (h_ctrl[2][7] && m_dest(2) != 5'd0 && m_dest(2) == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      h_ctrl[k] = '0; h_rs[k] = '0; h_rt[k] = '0; h_rd[k] = '0;
    end
  endtask

  task automatic model_check();
    logic st;
    st = m_stall();
    chk("ex_alusrc",    bus.ex_alusrc_o,    h_ctrl[0][0]);
    chk("ex_aluop",     bus.ex_aluop_o,     h_ctrl[0][2:1]);
    chk("ex_regdst",    bus.ex_regdst_o,    h_ctrl[0][3]);
    chk("mem_memread",  bus.mem_memread_o,  h_ctrl[1][5]);
    chk("mem_memwrite", bus.mem_memwrite_o, h_ctrl[1][6]);
    chk("wb_regwrite",  bus.wb_regwrite_o,  h_ctrl[2][7]);
    chk("wb_memtoreg",  bus.wb_memtoreg_o,  h_ctrl[2][8]);
    chk("wb_rd",        bus.wb_rd_o,        m_dest(2));
    chk("fwd_a",        bus.fwd_a_o,        m_fwd(h_rs[0]));
    chk("fwd_b",        bus.fwd_b_o,        m_fwd(h_rt[0]));
    chk("pc_write",     bus.pc_write_o,     !st);
    chk("ifid_write",   bus.ifid_write_o,   !st);
    chk("flush",        bus.flush_o,
        (bus.jump_i || (bus.branch_i && bus.eq_i)) && !st);
  endtask

  task automatic drive(input logic [8:0] c, input logic br, input logic jp, input logic eq,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    bus.ctrl_i = c; bus.branch_i = br; bus.jump_i = jp; bus.eq_i = eq;
    bus.rs_i = rs; bus.rt_i = rt; bus.rd_i = rd;
  endtask

  task automatic mid();
    #4;
    model_check();
  endtask

  task automatic adv();
    logic st;
    st = m_stall();
    @(posedge clk);
    for (int k = 2; k > 0; k--) begin
      h_ctrl[k] = h_ctrl[k-1]; h_rs[k] = h_rs[k-1];
      h_rt[k] = h_rt[k-1]; h_rd[k] = h_rd[k-1];
    end
    h_ctrl[0] = st ? 9'h000 : bus.ctrl_i;
    h_rs[0] = bus.rs_i; h_rt[0] = bus.rt_i; h_rd[0] = bus.rd_i;
    #1;
  endtask

  task automatic step(input logic [8:0] c, input logic br, input logic jp, input logic eq,
                      input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    drive(c, br, jp, eq, rs, rt, rd);
    mid();
    adv();
  endtask

  initial begin
    rst_i = 1'b0;
    drive(9'h000, 0, 0, 0, 0, 0, 0);
    model_clear();
    #3;
    model_check();
    chk("rst_pc_write", bus.pc_write_o, 1);
    bus.jump_i = 1'b1;
    #1;
    chk("rst_flush_follows", bus.flush_o, 1);
    bus.jump_i = 1'b0;
    #8;
    rst_i = 1'b1;
    adv();

    // R-type walk through all three stages
    step(9'h08E, 0, 0, 0, 5'd1, 5'd2, 5'd5);
    chk("walk_aluop", bus.ex_aluop_o, 2'b11);
    chk("walk_regdst", bus.ex_regdst_o, 1);
    step(9'h000, 0, 0, 0, 0, 0, 0);
    step(9'h000, 0, 0, 0, 0, 0, 0);
    chk("walk_wb_regwrite", bus.wb_regwrite_o, 1);
    chk("walk_wb_rd", bus.wb_rd_o, 5'd5);
    step(9'h000, 0, 0, 0, 0, 0, 0);

    // load-use: one stall cycle, bubble in EX
    step(9'h1A1, 0, 0, 0, 5'd0, 5'd8, 5'd0);
    drive(9'h08E, 0, 0, 0, 5'd8, 5'd9, 5'd10);
    mid();
    chk("lu_pc_write", bus.pc_write_o, 0);
    chk("lu_ifid_write", bus.ifid_write_o, 0);
    adv();
    chk("lu_bubble_ex", {bus.ex_alusrc_o, bus.ex_aluop_o, bus.ex_regdst_o}, 4'h0);
    mid();
    chk("lu_stall_cleared", bus.pc_write_o, 1);
    adv();

    // forwarding priority, then with destination r0
    step(9'h080, 0, 0, 0, 0, 5'd3, 0);
    step(9'h080, 0, 0, 0, 0, 5'd3, 0);
    step(9'h000, 0, 0, 0, 5'd3, 5'd4, 0);
    chk("fwd_prio_a", bus.fwd_a_o, 2'b10);
    chk("fwd_prio_b", bus.fwd_b_o, 2'b00);
    step(9'h080, 0, 0, 0, 0, 5'd0, 0);
    step(9'h080, 0, 0, 0, 0, 5'd0, 0);
    step(9'h000, 0, 0, 0, 5'd0, 5'd4, 0);
    chk("fwd_r0_a", bus.fwd_a_o, 2'b00);

    // flush cases
    drive(9'h000, 1, 0, 1, 0, 0, 0); mid(); chk("flush_beq_taken", bus.flush_o, 1); adv();
    drive(9'h000, 1, 0, 0, 0, 0, 0); mid(); chk("flush_beq_not", bus.flush_o, 0); adv();
    step(9'h1A1, 0, 0, 0, 5'd0, 5'd8, 5'd0);
    drive(9'h000, 0, 1, 0, 5'd8, 5'd0, 5'd0);
    mid(); chk("flush_jump_stalled", bus.flush_o, 0); adv();
    mid(); chk("flush_jump_next", bus.flush_o, 1); adv();

    // reset during a stall
    step(9'h1A1, 0, 0, 0, 5'd0, 5'd8, 5'd0);
    drive(9'h08E, 0, 0, 0, 5'd8, 5'd9, 5'd10);
    #2;
    chk("rst_pre_stall", bus.pc_write_o, 0);
    rst_i = 1'b0;
    #1;
    chk("rst_drops_stall", bus.pc_write_o, 1);
    model_clear();
    model_check();
    @(posedge clk);
    #2;
    rst_i = 1'b1;
    #2;
    adv();
    chk("rst_release_capture", bus.ex_aluop_o, 2'b11);

    // randomized traffic with occasional async reset
    for (int n = 0; n < 600; n++) begin
      drive(9'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 49) == 0) begin
        #2;
        rst_i = 1'b0;
        #1;
        model_clear();
        model_check();
        chk("rnd_rst_pc_write", bus.pc_write_o, 1);
        @(posedge clk);
        #2;
        rst_i = 1'b1;
      end else begin
        mid();
        adv();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl_pipe.md
HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

Interface
- REQ-001 SHALL have ports, one per line as name, direction, width, meaning:
  - clk_i  in  1  single clock, rising edge.
  - rst_i  in  1  reset; asynchronous, active-low.
  - ctrl_i  in  9  decoder control bundle: [0] ALUSrc, [2:1] ALUOp, [3] RegDst, [4] Branch, [5] MemRead, [6] MemWrite, [7] RegWrite, [8] MemToReg.
  - branch_i  in  1  decoder branch select.
  - jump_i  in  1  decoder jump select.
  - eq_i  in  1  ID-stage register-equality result.
  - rs_i, rt_i, rd_i  in  5 each  IF/ID instruction register fields.
  - ex_alusrc_o  out  1  ID/EX ALUSrc.
  - ex_aluop_o  out  2  ID/EX ALUOp.
  - ex_regdst_o  out  1  ID/EX RegDst.
  - mem_memread_o, mem_memwrite_o  out  1 each  EX/MEM memory controls.
  - wb_regwrite_o, wb_memtoreg_o  out  1 each  MEM/WB writeback controls.
  - wb_rd_o  out  5  MEM/WB destination register.
  - fwd_a_o, fwd_b_o  out  2 each  ALU operand forwarding selects.
  - pc_write_o, ifid_write_o  out  1 each  PC / IF-ID write enables.
  - flush_o  out  1  IF/ID flush.
- REQ-002 SHALL use one clock, clk_i; reset rst_i SHALL be asynchronous, active-low.

Function
- REQ-003 SHALL hold three stage registers, all updated every rising edge (no enable):
  - ID/EX: ctrl[8:0], rs, rt, rd.
  - EX/MEM: ctrl[8:5], dest.
  - MEM/WB: ctrl[8:7], dest.
- REQ-004 EX-stage dest SHALL be ID/EX rd when ID/EX RegDst=1, else ID/EX rt; it is captured into EX/MEM.
- REQ-005 Control latency SHALL be:
  - ctrl_i EX bits reach ex_* outputs 1 cycle after capture.
  - M bits reach mem_* outputs after 2 cycles.
  - WB bits reach wb_* outputs after 3 cycles.
- REQ-006 stall SHALL be combinational and asserted when all of: ID/EX MemRead=1, ID/EX rt!=0, and ID/EX rt equals rs_i or rt_i.
- REQ-007 While stall=1: pc_write_o=0, ifid_write_o=0, and ID/EX captures ctrl=9'h000 (bubble). rs/rt/rd are still captured.
- REQ-008 While stall=0: pc_write_o=1, ifid_write_o=1, and ID/EX captures ctrl_i.
- REQ-009 flush_o SHALL be combinational: (jump_i OR (branch_i AND eq_i)) AND NOT stall.
  - Stall has priority; the branch is re-evaluated on the following cycle.
- REQ-010 flush_o SHALL NOT alter ID/EX capture; the branch/jump instruction itself proceeds to EX.
- REQ-011 fwd_a_o SHALL be selected by priority:
  - 2'b10 when EX/MEM RegWrite=1, EX/MEM dest!=0, and EX/MEM dest equals ID/EX rs;
  - else 2'b01 when MEM/WB RegWrite=1, MEM/WB dest!=0, and MEM/WB dest equals ID/EX rs;
  - else 2'b00.
- REQ-012 fwd_b_o SHALL follow REQ-011 using ID/EX rt.
- REQ-013 When both EX/MEM and MEM/WB match, the EX/MEM match (2'b10) SHALL win.
- REQ-014 Register 0 SHALL never trigger forwarding or stall.
- REQ-015 A held stall SHALL persist for exactly one cycle per load-use pair; the bubble clears the ID/EX MemRead condition.
- REQ-016 All outputs other than pc_write_o, ifid_write_o, flush_o, fwd_a_o and fwd_b_o SHALL be driven directly from stage registers (no combinational path from inputs).

Reset
- REQ-017 While rst_i=0, all stage registers SHALL clear to 0 immediately, regardless of clock.
- REQ-018 Reset output values SHALL be:
  - all ex_*, mem_*, wb_* outputs = 0;
  - fwd_a_o = fwd_b_o = 2'b00;
  - pc_write_o = ifid_write_o = 1;
  - flush_o follows REQ-009 from inputs.
- REQ-019 Reset asserted mid-stall SHALL drop the stall in the same cycle; the first edge after release SHALL capture ctrl_i normally.

Verification
- REQ-020 Pipeline walk: R-type ctrl_i=9'h08E with rd=5, then 3 cycles of 9'h000. Required response:
  - ex_aluop_o=2'b11 and ex_regdst_o=1 at cycle 1;
  - wb_regwrite_o=1 and wb_rd_o=5 at cycle 3.
- REQ-021 Load-use: lw ctrl_i=9'h1A1 with rt=8, followed by rs_i=8. Required response:
  - stall for exactly one cycle: pc_write_o=0, ifid_write_o=0;
  - ex_* outputs all 0 in the next cycle.
- REQ-022 Forward priority: EX/MEM and MEM/WB both write reg 3, ID/EX rs=3, rt=4.
  - Required response: fwd_a_o=2'b10, fwd_b_o=2'b00.
  - Repeat with dest=0: fwd_a_o=2'b00.
- REQ-023 Flush cases:
  - branch_i=1, eq_i=1, no stall -> flush_o=1.
  - branch_i=1, eq_i=0 -> flush_o=0.
  - jump_i=1 during stall -> flush_o=0 that cycle, 1 the next.
- REQ-024 Async reset: drop rst_i mid-cycle with valid data in all stages.
  - Required response: all stage outputs 0 before the next edge; pc_write_o=1.
